// File: rtl/mux_n1_seq.sv
// mux_n1_seq: registered N_CH:1 mux with valid/ready output handshake; define MUX_N1_SEQ_SCAN_EN to add a round-robin scan mode
module mux_n1_seq #(
  parameter int N_CH = 8,
  parameter int W = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
`ifdef MUX_N1_SEQ_SCAN_EN
  input  logic              scan,
`endif
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH*W-1:0] d,
  output logic [W-1:0]      y,
  output logic [SEL_W-1:0]  y_ch,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              sel_err
);
  logic             fire;
  logic [SEL_W-1:0] ch;
  logic [W-1:0]     sel_data;
  logic             in_range;
  logic [W-1:0]     y_d, y_q;
  logic [SEL_W-1:0] y_ch_d, y_ch_q;
  logic             y_valid_d, y_valid_q;
  logic             sel_err_d, sel_err_q;
`ifdef MUX_N1_SEQ_SCAN_EN
  logic [SEL_W-1:0] ptr_d, ptr_q;
`endif
  // pick the channel, mux its data and compute next state; out-of-range channels read as zero
  always_comb begin
    fire = en && (!y_valid_q || y_ready);
`ifdef MUX_N1_SEQ_SCAN_EN
    ch = scan ? ptr_q : sel;
    ptr_d = (fire && scan) ? ((ptr_q == SEL_W'(N_CH - 1)) ? '0 : ptr_q + SEL_W'(1)) : ptr_q;
`else
    ch = sel;
`endif
    sel_data = '0;
    for (int k = 0; k < N_CH; k++)
      if (ch == SEL_W'(k)) sel_data = d[k*W +: W];
    in_range = 32'(ch) < N_CH;
    y_d = fire ? sel_data : y_q;
    y_ch_d = fire ? ch : y_ch_q;
    y_valid_d = fire || (y_valid_q && !y_ready);
    sel_err_d = fire ? !in_range : sel_err_q;
  end
  // state registers; reset wins over a same-cycle fire and discards any pending sample
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
      y_ch_q <= '0;
      y_valid_q <= 1'b0;
      sel_err_q <= 1'b0;
`ifdef MUX_N1_SEQ_SCAN_EN
      ptr_q <= '0;
`endif
    end else begin
      y_q <= y_d;
      y_ch_q <= y_ch_d;
      y_valid_q <= y_valid_d;
      sel_err_q <= sel_err_d;
`ifdef MUX_N1_SEQ_SCAN_EN
      ptr_q <= ptr_d;
`endif
    end
  end
  assign y = y_q;
  assign y_ch = y_ch_q;
  assign y_valid = y_valid_q;
  assign sel_err = sel_err_q;
endmodule

// File: tb/tb_mux_n1_seq.sv
// tb_mux_n1_seq: directed checks of mux_n1_seq with an 8x1 instance and a 6x4 instance
module tb_mux_n1_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, y_ready = 1'b1, scan = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] d = '0;
  logic [0:0] y;
  logic [2:0] y_ch;
  logic y_valid, sel_err;
  logic en6 = 1'b0, y_ready6 = 1'b1;
  logic [2:0] sel6 = '0;
  logic [23:0] d6 = '0;
  logic [3:0] y6;
  logic [2:0] y_ch6;
  logic y_valid6, sel_err6;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mux_n1_seq #(.N_CH(8), .W(1)) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef MUX_N1_SEQ_SCAN_EN
    .scan(scan),
`endif
    .sel(sel), .d(d), .y(y), .y_ch(y_ch), .y_valid(y_valid), .y_ready(y_ready), .sel_err(sel_err)
  );

  mux_n1_seq #(.N_CH(6), .W(4)) dut6 (
    .clk(clk), .rst(rst), .en(en6),
`ifdef MUX_N1_SEQ_SCAN_EN
    .scan(1'b0),
`endif
    .sel(sel6), .d(d6), .y(y6), .y_ch(y_ch6), .y_valid(y_valid6), .y_ready(y_ready6), .sel_err(sel_err6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    chk("rst_y", 32'(y), 0);
    chk("rst_valid", 32'(y_valid), 0);
    chk("rst_ch", 32'(y_ch), 0);
    chk("rst_err", 32'(sel_err), 0);
    en = 1'b1; sel = 3'd3; d = 8'hFF;
    tick();
    chk("rst_en_valid", 32'(y_valid), 0);
    chk("rst_en_y", 32'(y), 0);
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s); d = 8'd1 << s;
      tick();
      chk("onehot_y", 32'(y), 1);
      chk("onehot_ch", 32'(y_ch), 32'(s));
      chk("onehot_valid", 32'(y_valid), 1);
      d = ~(8'd1 << s);
      tick();
      chk("inv_y", 32'(y), 0);
      chk("inv_ch", 32'(y_ch), 32'(s));
    end
    en = 1'b0;
    tick();
    chk("drain_valid", 32'(y_valid), 0);
    chk("drain_ch", 32'(y_ch), 7);
    d = 8'hFF; sel = 3'd1;
    tick();
    chk("idle_d_y", 32'(y), 0);
    chk("idle_d_ch", 32'(y_ch), 7);
    en = 1'b1; sel = 3'd2; d = 8'h04;
    tick();
    chk("bp_load_y", 32'(y), 1);
    chk("bp_load_ch", 32'(y_ch), 2);
    y_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom); sel = 3'(i + 3); en = i[0];
      tick();
      chk("bp_y", 32'(y), 1);
      chk("bp_ch", 32'(y_ch), 2);
      chk("bp_valid", 32'(y_valid), 1);
    end
    y_ready = 1'b1; en = 1'b1; sel = 3'd5; d = 8'h00;
    tick();
    chk("bp_release_y", 32'(y), 0);
    chk("bp_release_ch", 32'(y_ch), 5);
    chk("bp_release_valid", 32'(y_valid), 1);
    y_ready = 1'b0; sel = 3'd3; d = 8'h08;
    tick();
    chk("bp_hold_ch", 32'(y_ch), 5);
    y_ready = 1'b1;
    tick();
    chk("bp_new_y", 32'(y), 1);
    chk("bp_new_ch", 32'(y_ch), 3);
    y_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_bp_y", 32'(y), 0);
    chk("rst_bp_valid", 32'(y_valid), 0);
    chk("rst_bp_ch", 32'(y_ch), 0);
    rst = 1'b0; en = 1'b0; y_ready = 1'b1;
    d6 = 24'hABCDEF; sel6 = 3'd7; en6 = 1'b1;
    tick();
    chk("oor_y", 32'(y6), 0);
    chk("oor_ch", 32'(y_ch6), 7);
    chk("oor_err", 32'(sel_err6), 1);
    chk("oor_valid", 32'(y_valid6), 1);
    sel6 = 3'd2;
    tick();
    chk("inr_y", 32'(y6), 32'hD);
    chk("inr_ch", 32'(y_ch6), 2);
    chk("inr_err", 32'(sel_err6), 0);
    sel6 = 3'd6;
    tick();
    chk("oor6_err", 32'(sel_err6), 1);
    y_ready6 = 1'b0; sel6 = 3'd5;
    tick();
    chk("oor_bp_err", 32'(sel_err6), 1);
    chk("oor_bp_ch", 32'(y_ch6), 6);
    y_ready6 = 1'b1;
    tick();
    chk("w4_y", 32'(y6), 32'hA);
    chk("w4_err", 32'(sel_err6), 0);
    en6 = 1'b0;
`ifdef MUX_N1_SEQ_SCAN_EN
    rst = 1'b1;
    tick();
    rst = 1'b0; scan = 1'b1; en = 1'b1; y_ready = 1'b1; sel = 3'd7; d = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("scan_ch", 32'(y_ch), 32'(i % 8));
      chk("scan_err", 32'(sel_err), 0);
    end
    scan = 1'b0; sel = 3'd6;
    tick();
    chk("manual_ch", 32'(y_ch), 6);
    scan = 1'b1;
    tick();
    chk("scan_resume_ch", 32'(y_ch), 2);
    y_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("scan_rst_valid", 32'(y_valid), 0);
    rst = 1'b0; y_ready = 1'b1;
    tick();
    chk("scan_after_rst_ch", 32'(y_ch), 0);
    en = 1'b0; scan = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
